pwm_signed_multi: RTL

Multi-channel signed-compare PWM generator with one shared carrier counter, a runtime-programmable period and edge- or center-aligned carrier. Duty and configuration writes are double-buffered so outputs never glitch mid-period. Sits between control-loop arithmetic (signed duty words) and pad drivers or gate-drive logic. It succeeds the single-channel fixed-period signed PWM.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_carrier.sv | 83 ++++++++
 rtl/pwm_signed_multi.sv | 107 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel signed PWM.
// Widths are fixed per instance; MAX_W bounds the package-level helpers.
package pwm_pkg;

    localparam int unsigned MAX_W = 16;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } pwm_mode_e;

    // Widest signed duty word; instances narrow it to their own W.
    typedef logic signed [MAX_W-1:0] duty_max_t;

    // Map a raw unsigned half-period onto the legal range 1..2^(w-1).
    function automatic logic [MAX_W-1:0] clamp_half(input logic [MAX_W-1:0] raw,
                                                    input int unsigned      w);
        logic [MAX_W-1:0] lim;
        lim = MAX_W'(1) << (w - 1);
        if (raw == '0) begin
            return MAX_W'(1);
        end else if (raw > lim) begin
            return lim;
        end else begin
            return raw;
        end
    endfunction

endpackage

// File: rtl/pwm_carrier.sv
// Shared signed carrier counter: edge or center aligned, active half-period and mode
// reload only at the period boundary or while disabled.
module pwm_carrier
    import pwm_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [W-1:0]        half_next,
    input  logic                mode_next,
    output logic signed [W-1:0] cnt,
    output logic [W-1:0]        half_act,
    output logic                mode_act,
    output logic                boundary
);

    localparam logic [W-1:0] HalfRst = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] cnt_q, cnt_d;
    logic                dir_q, dir_d;  // 1 = counting down (center mode only)
    logic [W-1:0]        half_q, half_d;
    pwm_mode_e           mode_q, mode_d;

    logic signed [W-1:0] top_val;
    logic signed [W-1:0] bot_val;
    logic signed [W-1:0] start_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= $signed(HalfRst);
            dir_q  <= 1'b0;
            half_q <= HalfRst;
            mode_q <= EDGE;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            half_q <= half_d;
            mode_q <= mode_d;
        end
    end

    always_comb begin
        top_val   = $signed(half_q - W'(1));
        bot_val   = $signed(W'(1) - half_q);
        start_val = $signed(W'(0) - half_next);

        // H=1 in center mode degenerates to the same two-step sequence as edge mode.
        if (!en) begin
            boundary = 1'b0;
        end else if (mode_q == EDGE || half_q == W'(1)) begin
            boundary = (cnt_q == top_val);
        end else begin
            boundary = dir_q && (cnt_q == bot_val);
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        half_d = half_q;
        mode_d = mode_q;
        if (!en || boundary) begin
            half_d = half_next;
            mode_d = pwm_mode_e'(mode_next);
            cnt_d  = start_val;
            dir_d  = 1'b0;
        end else if (mode_q == CENTER && !dir_q && cnt_q == top_val) begin
            dir_d = 1'b1;
            cnt_d = cnt_q - W'(1);
        end else if (dir_q) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    assign cnt      = cnt_q;
    assign half_act = half_q;
    assign mode_act = mode_q;

endmodule

// File: rtl/pwm_signed_multi.sv
// Multi-channel signed-compare PWM: double-buffered duty and carrier configuration,
// one shared carrier, registered outputs.
module pwm_signed_multi
    import pwm_pkg::*;
#(
    parameter  int unsigned CH  = 4,
    parameter  int unsigned W   = 8,
    localparam int unsigned ChW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_wr,
    input  logic [W-1:0]        cfg_half,
    input  logic                cfg_mode,
    input  logic                wr_en,
    input  logic [ChW-1:0]      wr_ch,
    input  logic signed [W-1:0] wr_data,
    output logic [CH-1:0]       pwm,
    output logic                co,
    output logic                upd
);

    typedef logic signed [W-1:0] duty_t;

    localparam logic [W-1:0] HalfRst = {1'b1, {(W-1){1'b0}}};
    localparam duty_t        DutyRst = $signed(HalfRst);

    duty_t duty_sh_q  [CH];
    duty_t duty_sh_d  [CH];
    duty_t duty_act_q [CH];
    duty_t duty_act_d [CH];

    logic [W-1:0]     half_sh_q, half_sh_d;
    logic             mode_sh_q, mode_sh_d;
    logic [MAX_W-1:0] half_clamped;

    logic signed [W-1:0] cnt;
    logic [W-1:0]        half_act;
    logic                mode_act;
    logic                boundary;
    logic                load;
    logic                differ;
    logic [CH-1:0]       pwm_d;
    logic                upd_d;

    pwm_carrier #(
        .W (W)
    ) u_carrier (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .half_next (half_sh_d),
        .mode_next (mode_sh_d),
        .cnt       (cnt),
        .half_act  (half_act),
        .mode_act  (mode_act),
        .boundary  (boundary)
    );

    // Active set follows shadow at every boundary and continuously while disabled.
    assign load = boundary || !en;
    assign co   = boundary;

    always_comb begin
        half_clamped = clamp_half(MAX_W'(cfg_half), W);
        half_sh_d    = cfg_wr ? half_clamped[W-1:0] : half_sh_q;
        mode_sh_d    = cfg_wr ? cfg_mode : mode_sh_q;
    end

    // Shadow next-values feed the active load, giving write-through on a boundary.
    always_comb begin
        differ = (half_sh_d != half_act) || (mode_sh_d != mode_act);
        for (int i = 0; i < CH; i++) begin
            duty_sh_d[i]  = (wr_en && wr_ch == ChW'(i)) ? wr_data : duty_sh_q[i];
            duty_act_d[i] = load ? duty_sh_d[i] : duty_act_q[i];
            pwm_d[i]      = en && (duty_act_q[i] > cnt);
            if (duty_sh_d[i] != duty_act_q[i]) begin
                differ = 1'b1;
            end
        end
        upd_d = boundary && differ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_sh_q <= HalfRst;
            mode_sh_q <= 1'b0;
            pwm       <= '0;
            upd       <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                duty_sh_q[i]  <= DutyRst;
                duty_act_q[i] <= DutyRst;
            end
        end else begin
            half_sh_q <= half_sh_d;
            mode_sh_q <= mode_sh_d;
            pwm       <= pwm_d;
            upd       <= upd_d;
            for (int i = 0; i < CH; i++) begin
                duty_sh_q[i]  <= duty_sh_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

endmodule
